// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-button pad and its conditioner.
// The conditioner drives the slave side; the pad/bench drives btn_in on the master side.
interface button_conditioner_if;
  // Event outputs are single-cycle strobes with no valid/ready pairing and no
  // backpressure: a consumer must sample them every clk cycle or miss them.
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [1:0] state_dbg;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  state_dbg
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output state_dbg
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, two-edge debounce FSM and
// registered press / release / long-press pulses plus a debounced level.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 100000,
  parameter int LONG_PRESS_CYCLES = 20000000
) (
  input logic                 clk,
  input logic                 resetb,
  button_conditioner_if.slave btn
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic          s1;
  logic          btn_sync;
  logic [1:0]    state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_done;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn.btn_in;
      btn_sync <= s1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= HELD;
            press_q   <= 1'b1;
            level_q   <= 1'b1;
            hold_cnt  <= '0;
            long_done <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end else if (!long_done) begin
            // hold_cnt freezes once the long press has fired, so it never wraps
            if (hold_cnt == HOLD_LAST) begin
              long_q    <= 1'b1;
              long_done <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          // A short low glitch returns to HELD with the hold time preserved
          if (btn_sync) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= IDLE;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;
  assign btn.state_dbg     = state;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table-driven level segments with a timed
// event scoreboard, plus a hand-written reset-during-hold sequence.
module tb_button_conditioner;

  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int LAT  = DEB + 3;
  localparam int W    = 34;

  localparam logic [1:0] EV_NONE    = 2'd0;
  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;
  localparam logic [1:0] EV_LONG    = 2'd3;

  typedef struct {
    logic       btn;
    int         cycles;
    logic [1:0] ev;
    logic       exp_long;
    logic       exp_level;
  } vec_t;

  logic clk;
  logic resetb;
  int   cyc;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .btn   (bif)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard: compares every pulse against the timed expectation queue
  always @(negedge clk) begin
    if (resetb) begin
      int n;
      logic [1:0]   k;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      n = int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.long_pulse);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL pulse_exclusive: %0d pulses high at cycle %0d", n, cyc);
      end
      if (n != 0) begin
        k   = bif.press_pulse ? EV_PRESS : (bif.release_pulse ? EV_RELEASE : EV_LONG);
        got = {k, 32'(cyc)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp)begin
            errors++;
            $display("FAIL pulse_event: got kind %0d cycle %0d expected kind %0d cycle %0d",
                     k, cyc, exp[33:32], exp[31:0]);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0][31:0] < 32'(cyc)) begin
        exp = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: kind %0d expected at cycle %0d, absent at cycle %0d",
                 exp[33:32], exp[31:0], cyc);
      end
    end
  end

  // driver: apply one level segment, register its expected events, check level
  task automatic apply_vec(input vec_t v, input int idx);
    int c;
    c = cyc;
    bif.btn_in = v.btn;
    if (v.ev != EV_NONE) exp_q.push_back({v.ev, 32'(c + LAT)});
    if (v.exp_long) exp_q.push_back({EV_LONG, 32'(c + LAT + LONG)});
    repeat (v.cycles) @(negedge clk);
    check($sformatf("level_vec%0d", idx), 32'(bif.btn_level), 32'(v.exp_level));
  endtask

  task automatic push_vec(input logic b, input int n, input logic [1:0] ev,
                          input logic lg, input logic lvl);
    vec_t v;
    v.btn = b; v.cycles = n; v.ev = ev; v.exp_long = lg; v.exp_level = lvl;
    vecs.push_back(v);
  endtask

  initial begin
    int c;
    checks = 0;
    errors = 0;
    resetb = 1'b0;
    bif.btn_in = 1'b0;

    push_vec(1'b0, 10, EV_NONE,    1'b0, 1'b0);
    push_vec(1'b1, 60, EV_PRESS,   1'b1, 1'b1);
    push_vec(1'b0, 5,  EV_NONE,    1'b0, 1'b1);
    push_vec(1'b1, 15, EV_NONE,    1'b0, 1'b1);
    push_vec(1'b0, 20, EV_RELEASE, 1'b0, 1'b0);
    push_vec(1'b1, 6,  EV_NONE,    1'b0, 1'b0);
    push_vec(1'b0, 15, EV_NONE,    1'b0, 1'b0);
    for (int i = 0; i < 14; i++) push_vec(((i % 2) == 0), 3, EV_NONE, 1'b0, 1'b0);
    push_vec(1'b1, 50, EV_PRESS,   1'b1, 1'b1);
    push_vec(1'b0, 20, EV_RELEASE, 1'b0, 1'b0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_level",   32'(bif.btn_level),     32'd0);
    check("rst_press",   32'(bif.press_pulse),   32'd0);
    check("rst_release", 32'(bif.release_pulse), 32'd0);
    check("rst_long",    32'(bif.long_pulse),    32'd0);
    check("rst_state",   32'(bif.state_dbg),     32'd0);
    resetb = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // reset asserted while HELD drops everything at once
    c = cyc;
    bif.btn_in = 1'b1;
    exp_q.push_back({EV_PRESS, 32'(c + LAT)});
    repeat (LAT + 5) @(negedge clk);
    check("held_level", 32'(bif.btn_level), 32'd1);
    check("held_state", 32'(bif.state_dbg), 32'd2);
    resetb = 1'b0;
    #1;
    check("midrst_level",   32'(bif.btn_level),     32'd0);
    check("midrst_press",   32'(bif.press_pulse),   32'd0);
    check("midrst_release", 32'(bif.release_pulse), 32'd0);
    check("midrst_long",    32'(bif.long_pulse),    32'd0);
    check("midrst_state",   32'(bif.state_dbg),     32'd0);
    bif.btn_in = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_level", 32'(bif.btn_level), 32'd0);
    check("post_rst_state", 32'(bif.state_dbg), 32'd0);

    // drain with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
